// File: rtl/dadda_op_sequencer.sv
// -----------------------------------------------------------------------------
// dadda_op_sequencer
//   Batch sequencer for the 16x16 Dadda multiplier. Streams NUM_OPS operand
//   words out of the operand BRAM (port A), hands a/b to the fixed-latency
//   multiplier and writes each 32-bit product to the result BRAM (port B).
//
//   Optional feature macro: SIGNATURE_EN
//     defined   : signature accumulates dinb on every web (mod 2**32)
//     undefined : no accumulator, signature is tied to 0
//
// Ports
//   clka, reset           clock (rising edge), asynchronous active-high reset
//   start, abort          run request / kill (abort wins)
//   addra, ena, douta     operand BRAM read port; douta = {a, b}
//   a, b, mul_valid, p    multiplier interface; p has no valid, tracked here
//   addrb, web, dinb      result BRAM write port
//   busy, done, count     status: RUN|DRAIN, DONE level, products written
//   signature             product checksum
// -----------------------------------------------------------------------------
module dadda_op_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int NUM_OPS = 16,
    parameter int RD_LAT  = 1,
    parameter int MUL_LAT = 3
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] addra,
    output logic              ena,
    input  logic [31:0]       douta,
    output logic [15:0]       a,
    output logic [15:0]       b,
    output logic              mul_valid,
    input  logic [31:0]       p,
    output logic [ADDR_W-1:0] addrb,
    output logic              web,
    output logic [31:0]       dinb,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [31:0]       signature
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_OPS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;     // doubles as the issue counter
    logic                ena_q, ena_d;
    logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;   // [RD_LAT-1] => douta valid now
    logic [15:0]         a_q, a_d, b_q, b_d;
    logic                mul_valid_q, mul_valid_d;
    logic [MUL_LAT-1:0]  mul_pipe_q, mul_pipe_d; // [MUL_LAT-1] => p valid now
    logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0]   addrb_q, addrb_d;
    logic                web_q, web_d;
    logic [31:0]         dinb_q, dinb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     count_q, count_d;
`ifdef SIGNATURE_EN
    logic [31:0]         sig_q, sig_d;
`endif
    logic                in_flight;

    always_comb begin
        state_d     = state_q;
        addra_d     = addra_q;
        ena_d       = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        addrb_d     = addrb_q;
        dinb_d      = dinb_q;
        wr_idx_d    = wr_idx_q;
        count_d     = count_q;
`ifdef SIGNATURE_EN
        sig_d       = sig_q;
`endif

        // Read-latency and multiplier-latency valid shift registers.
        rd_vld_d    = '0;
        rd_vld_d[0] = ena_q;
        for (int i = 1; i < RD_LAT; i++) rd_vld_d[i] = rd_vld_q[i-1];
        mul_pipe_d    = '0;
        mul_pipe_d[0] = mul_valid_q;
        for (int i = 1; i < MUL_LAT; i++) mul_pipe_d[i] = mul_pipe_q[i-1];

        mul_valid_d = rd_vld_q[RD_LAT-1];
        if (rd_vld_q[RD_LAT-1]) begin
            a_d = douta[31:16];
            b_d = douta[15:0];
        end

        web_d = mul_pipe_q[MUL_LAT-1];
        if (mul_pipe_q[MUL_LAT-1]) begin
            dinb_d   = p;
            addrb_d  = wr_idx_q;
            // Saturate so addrb never wraps past the last result slot.
            wr_idx_d = (wr_idx_q == LAST) ? wr_idx_q : wr_idx_q + 1'b1;
        end

        if (web_q) begin
            count_d = count_q + 1'b1;
`ifdef SIGNATURE_EN
            sig_d   = sig_q + dinb_q;
`endif
        end

        in_flight = (|rd_vld_q) | mul_valid_q | (|mul_pipe_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    ena_d    = 1'b1;
                    addra_d  = '0;
                    wr_idx_d = '0;
                    count_d  = '0;
`ifdef SIGNATURE_EN
                    sig_d    = '0;
`endif
                end
            end
            S_RUN: begin
                if (addra_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    ena_d   = 1'b1;
                    addra_d = addra_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Last web is on the wire this cycle once nothing is in flight.
                if (!in_flight) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort kills everything in flight; results so far are frozen.
        if (abort) begin
            state_d     = S_IDLE;
            ena_d       = 1'b0;
            addra_d     = addra_q;
            rd_vld_d    = '0;
            mul_valid_d = 1'b0;
            mul_pipe_d  = '0;
            web_d       = 1'b0;
            a_d         = a_q;
            b_d         = b_q;
            addrb_d     = addrb_q;
            dinb_d      = dinb_q;
            wr_idx_d    = wr_idx_q;
            count_d     = count_q;
`ifdef SIGNATURE_EN
            sig_d       = sig_q;
`endif
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addra_q     <= '0;
            ena_q       <= 1'b0;
            rd_vld_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mul_valid_q <= 1'b0;
            mul_pipe_q  <= '0;
            wr_idx_q    <= '0;
            addrb_q     <= '0;
            web_q       <= 1'b0;
            dinb_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
`ifdef SIGNATURE_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addra_q     <= addra_d;
            ena_q       <= ena_d;
            rd_vld_q    <= rd_vld_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mul_valid_q <= mul_valid_d;
            mul_pipe_q  <= mul_pipe_d;
            wr_idx_q    <= wr_idx_d;
            addrb_q     <= addrb_d;
            web_q       <= web_d;
            dinb_q      <= dinb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
`ifdef SIGNATURE_EN
            sig_q       <= sig_d;
`endif
        end
    end

    assign addra     = addra_q;
    assign ena       = ena_q;
    assign a         = a_q;
    assign b         = b_q;
    assign mul_valid = mul_valid_q;
    assign addrb     = addrb_q;
    assign web       = web_q;
    assign dinb      = dinb_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
`ifdef SIGNATURE_EN
    assign signature = sig_q;
`else
    assign signature = 32'd0;
`endif

endmodule

// File: tb/tb_dadda_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dadda_op_sequencer
//   Scoreboard bench. The driver pushes one expected write per operand when it
//   issues start; a negedge monitor pops on every web and also checks the ena /
//   addra window. A second instance with NUM_OPS=1 covers the single-op run.
// -----------------------------------------------------------------------------
module tb_dadda_op_sequencer;
    localparam int AW = 4;
    localparam int N  = 16;

    logic clka = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, start1 = 1'b0;
    always #5 clka = ~clka;

    logic [AW-1:0] addra, addrb;
    logic          ena, mul_valid, web, busy, done;
    logic [31:0]   douta, p, dinb, signature;
    logic [15:0]   a, b;
    logic [AW:0]   count;

    logic [AW-1:0] addra1, addrb1;
    logic          ena1, mul_valid1, web1, busy1, done1;
    logic [31:0]   douta1, p1, dinb1, signature1;
    logic [15:0]   a1, b1;
    logic [AW:0]   count1;

    dadda_op_sequencer #(.ADDR_W(AW), .NUM_OPS(N), .RD_LAT(1), .MUL_LAT(3)) u_dut (
        .clka(clka), .reset(reset), .start(start), .abort(abort),
        .addra(addra), .ena(ena), .douta(douta), .a(a), .b(b), .mul_valid(mul_valid),
        .p(p), .addrb(addrb), .web(web), .dinb(dinb), .busy(busy), .done(done),
        .count(count), .signature(signature));

    dadda_op_sequencer #(.ADDR_W(AW), .NUM_OPS(1), .RD_LAT(1), .MUL_LAT(3)) u_dut1 (
        .clka(clka), .reset(reset), .start(start1), .abort(1'b0),
        .addra(addra1), .ena(ena1), .douta(douta1), .a(a1), .b(b1), .mul_valid(mul_valid1),
        .p(p1), .addrb(addrb1), .web(web1), .dinb(dinb1), .busy(busy1), .done(done1),
        .count(count1), .signature(signature1));

    // Environment: 1-cycle operand BRAM and 3-stage multiplier for each DUT.
    logic [31:0] rom  [0:N-1];
    logic [31:0] rom1 [0:N-1];
    logic [31:0] m1, m2, n1, n2;
    always @(posedge clka) begin
        if (ena)  douta  <= rom[addra];
        if (ena1) douta1 <= rom1[addra1];
        m1 <= {16'd0, a}  * {16'd0, b};  m2 <= m1; p  <= m2;
        n1 <= {16'd0, a1} * {16'd0, b1}; n2 <= n1; p1 <= n2;
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [31:0] data; } exp_t;
    exp_t q[$];
    int   checks = 0, failures = 0;
    int   en_lo = -1, en_hi = -2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    function automatic logic [31:0] prod(input logic [31:0] w);
        return {16'd0, w[31:16]} * {16'd0, w[15:0]};
    endfunction

    function automatic logic [31:0] exp_sig(input int nw);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < nw; k++) s = s + prod(rom[k]);
`ifdef SIGNATURE_EN
        return s;
`else
        return (s == s) ? 32'd0 : 32'd1;
`endif
    endfunction

    // Monitor: ena window, scoreboard of result writes, signature tie-off.
    exp_t mon_e;
    logic mon_en;
    always @(negedge clka) begin
        if (!reset) begin
            mon_en = (cyc >= en_lo) && (cyc <= en_hi);
            chk("ena", 64'(ena), 64'(mon_en));
            if (mon_en) chk("addra", 64'(addra), 64'(cyc - en_lo));
            while (q.size() > 0 && q[0].cyc < cyc) begin
                mon_e = q.pop_front();
                chk("missed_web_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
            if (web) begin
                if (q.size() == 0) begin
                    chk("unexpected_web", 64'(web), 64'(0));
                end else begin
                    mon_e = q.pop_front();
                    chk("web_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("addrb", 64'(addrb), 64'(mon_e.addr));
                    chk("dinb", 64'(dinb), 64'(mon_e.data));
                end
            end
`ifndef SIGNATURE_EN
            chk("signature_zero", 64'(signature), 64'(0));
`endif
        end
    end

    // Start a run in the current cycle; returns the start cycle s.
    task automatic start_run(output int s);
        @(negedge clka);
        start = 1'b1;
        s = cyc;
        en_lo = s + 1;
        en_hi = s + N;
        for (int k = 0; k < N; k++) begin
            exp_t e;
            e.cyc = s + 7 + k;
            e.addr = AW'(k);
            e.data = prod(rom[k]);
            q.push_back(e);
        end
        @(negedge clka);
        start = 1'b0;
        chk("busy_run", 64'(busy), 64'(1));
        chk("done_low_run", 64'(done), 64'(0));
    endtask

    task automatic wait_done(input int s, input logic [31:0] esig);
        int i;
        i = 0;
        while (!done && i < 100) begin @(negedge clka); i++; end
        chk("done_cycle", 64'(cyc), 64'(s + N + 7));
        chk("count", 64'(count), 64'(N));
        chk("signature", 64'(signature), 64'(esig));
        chk("busy_done", 64'(busy), 64'(0));
        chk("sb_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic abort_run(input int s, input int off);
        int ab, nw;
        while (cyc < s + off) @(negedge clka);
        abort = 1'b1;
        ab = cyc;
        if (en_hi > ab) en_hi = ab;
        while (q.size() > 0 && q[$].cyc > ab) void'(q.pop_back());
        nw = ab - s - 7;
        if (nw < 0) nw = 0;
        if (nw > N) nw = N;
        @(negedge clka);
        abort = 1'b0;
        chk("abort_ctl", 64'({ena, mul_valid, web, busy, done}), 64'(0));
        chk("abort_count", 64'(count), 64'(nw));
        chk("abort_sig", 64'(signature), 64'(exp_sig(nw)));
        repeat (12) @(negedge clka);
        chk("abort_count_hold", 64'(count), 64'(nw));
        chk("abort_sb_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        int s, ne, nweb, wc;
        logic [31:0] wd, sig1;
        for (int k = 0; k < N; k++) begin
            rom[k]  = {16'(k + 1), 16'(k + 2)};
            rom1[k] = 32'd0;
        end
        rom1[0] = 32'hFFFF_FFFF;

        // Reset state
        repeat (3) @(negedge clka);
        chk("reset_ctl", 64'({ena, mul_valid, web, busy, done}), 64'(0));
        chk("reset_count_sig", 64'({count, signature}), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clka);

        // Full run with the incrementing ROM
`ifdef SIGNATURE_EN
        sig1 = 32'd1632;
`else
        sig1 = 32'd0;
`endif
        start_run(s);
        wait_done(s, sig1);

        // Start pulses during RUN and DRAIN are ignored (restart from DONE)
        start_run(s);
        while (cyc < s + 5) @(negedge clka);
        start = 1'b1; @(negedge clka); start = 1'b0;
        while (cyc < s + 18) @(negedge clka);
        start = 1'b1; @(negedge clka); start = 1'b0;
        wait_done(s, sig1);

        // Abort in the 8th RUN cycle
        start_run(s);
        abort_run(s, 8);

        // start and abort together in IDLE: stays idle
        @(negedge clka);
        start = 1'b1; abort = 1'b1;
        @(negedge clka);
        start = 1'b0; abort = 1'b0;
        repeat (4) @(negedge clka);
        chk("idle_start_abort", 64'({ena, busy, done}), 64'(0));

        // Async reset mid-DRAIN, then a clean run
        start_run(s);
        while (cyc < s + 19) @(negedge clka);
        #1 reset = 1'b1;
        #1;
        chk("rst_ctl", 64'({ena, mul_valid, web, busy, done}), 64'(0));
        chk("rst_addr", 64'({addra, addrb, count}), 64'(0));
        chk("rst_data", {a, b, dinb}, 64'(0));
        chk("rst_sig", 64'(signature), 64'(0));
        q.delete();
        en_lo = -1; en_hi = -2;
        @(negedge clka);
        reset = 1'b0;
        @(negedge clka);
        start_run(s);
        wait_done(s, sig1);

        // Randomized runs, some aborted at a random point
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) rom[k] = $urandom;
            if (r == 0) rom[N-1] = 32'hFFFF_FFFF;
            repeat ($urandom_range(0, 3)) @(negedge clka);
            start_run(s);
            if ($urandom_range(0, 1) == 1) abort_run(s, int'($urandom_range(1, N + 6)));
            else                           wait_done(s, exp_sig(N));
        end

        // NUM_OPS=1 instance: one-cycle RUN, single write of 0xFFFE0001
        @(negedge clka);
        start1 = 1'b1;
        s = cyc;
        @(negedge clka);
        start1 = 1'b0;
        ne = 0; nweb = 0; wc = -1; wd = 32'd0;
        for (int i = 0; i < 14; i++) begin
            ne += int'(ena1);
            if (web1) begin nweb++; wd = dinb1; wc = cyc; end
            @(negedge clka);
        end
        chk("one_ena_cycles", 64'(ne), 64'(1));
        chk("one_web_count", 64'(nweb), 64'(1));
        chk("one_dinb", 64'(wd), 64'(32'hFFFE_0001));
        chk("one_web_cycle", 64'(wc), 64'(s + 7));
        chk("one_count", 64'(count1), 64'(1));
        chk("one_done", 64'({done1, busy1}), 64'(2));
        chk("one_addrb", 64'(addrb1), 64'(0));
`ifdef SIGNATURE_EN
        chk("one_sig", 64'(signature1), 64'(32'hFFFE_0001));
`else
        chk("one_sig", 64'(signature1), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
